capture_fifo: RTL and testbench

- Downstream stage for the parameterised XOR processing block; it consumes that block's `ovG_data` output.
- Captures one data word per enabled cycle into a first-word-fall-through FIFO.
- Delivers the words to the next consumer over a valid/ready handshake.
- Reports occupancy and keeps a saturating count of words dropped because the FIFO was full.

---
 rtl/capture_fifo.sv | 115 +++++++++++
 tb/tb_capture_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through capture buffer behind the XOR stage.
// Registered head/status outputs, valid/ready drain, saturating drop count.
module capture_fifo #(
    parameter int PAR_DATA_BITS     = 16,
    parameter int PAR_DEPTH_LOG2    = 3,
    parameter int PAR_DROP_CNT_BITS = 8
) (
    input  logic                         ib_clk,
    input  logic                         ib_rst,
    input  logic                         ib_capture_en,
    input  logic [PAR_DATA_BITS-1:0]     ivG_data,
    input  logic                         ib_clr_drop,
    output logic                         ob_valid,
    input  logic                         ib_ready,
    output logic [PAR_DATA_BITS-1:0]     ovG_data,
    output logic [PAR_DEPTH_LOG2:0]      ovG_level,
    output logic                         ob_full,
    output logic                         ob_empty,
    output logic [PAR_DROP_CNT_BITS-1:0] ovG_drop_cnt
);

    localparam logic [PAR_DEPTH_LOG2:0] LP_DEPTH =
        {1'b1, {PAR_DEPTH_LOG2{1'b0}}};
    localparam logic [PAR_DROP_CNT_BITS-1:0] LP_DROP_MAX = '1;

    logic [PAR_DATA_BITS-1:0]     r_mem [2**PAR_DEPTH_LOG2];
    logic [PAR_DEPTH_LOG2-1:0]    r_wr_ptr;
    logic [PAR_DEPTH_LOG2-1:0]    r_rd_ptr;
    logic [PAR_DEPTH_LOG2:0]      r_level;
    logic                         r_full;
    logic                         r_empty;
    logic [PAR_DATA_BITS-1:0]     r_data;
    logic [PAR_DROP_CNT_BITS-1:0] r_drop_cnt;

    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic [PAR_DEPTH_LOG2:0]      w_level_n;
    logic [PAR_DEPTH_LOG2-1:0]    w_rd_ptr_n;
    logic [PAR_DATA_BITS-1:0]     w_head_n;

    assign w_pop      = !r_empty & ib_ready;
    assign w_push     = ib_capture_en & (!r_full | w_pop);
    assign w_drop     = ib_capture_en & r_full & !w_pop;
    assign w_rd_ptr_n = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    // Next occupancy from the push/pop pair.
    always_comb begin
        w_level_n = r_level;
        if (w_push && !w_pop) begin
            w_level_n = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_n = r_level - 1'b1;
        end
    end

    // Next head word; a write landing on the new head slot bypasses the array.
    always_comb begin
        w_head_n = r_data;
        if (w_level_n != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_n)) begin
                w_head_n = ivG_data;
            end else begin
                w_head_n = r_mem[w_rd_ptr_n];
            end
        end
    end

    // Storage array; contents need no reset since the head is registered.
    always_ff @(posedge ib_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ivG_data;
        end
    end

    // Pointers, level, status flags and the registered head word.
    always_ff @(posedge ib_clk or negedge ib_rst) begin
        if (!ib_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_n;
            r_level  <= w_level_n;
            r_full   <= (w_level_n == LP_DEPTH);
            r_empty  <= (w_level_n == '0);
            r_data   <= w_head_n;
        end
    end

    // Saturating drop counter; a clear coinciding with a drop leaves one.
    always_ff @(posedge ib_clk or negedge ib_rst) begin
        if (!ib_rst) begin
            r_drop_cnt <= '0;
        end else if (ib_clr_drop) begin
            r_drop_cnt <= w_drop ? {{(PAR_DROP_CNT_BITS-1){1'b0}}, 1'b1} : '0;
        end else if (w_drop && (r_drop_cnt != LP_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign ob_valid     = !r_empty;
    assign ob_empty     = r_empty;
    assign ob_full      = r_full;
    assign ovG_level    = r_level;
    assign ovG_data     = r_data;
    assign ovG_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_capture_fifo.sv
// tb_capture_fifo: directed checks of capture_fifo ordering, overflow,
// wrap, drop saturation/clear and asynchronous reset.
module tb_capture_fifo;

    logic        ib_clk;
    logic        ib_rst;
    logic        ib_capture_en;
    logic [15:0] ivG_data;
    logic        ib_clr_drop;
    logic        ib_ready;

    logic        ob_valid;
    logic [15:0] ovG_data;
    logic [3:0]  ovG_level;
    logic        ob_full;
    logic        ob_empty;
    logic [7:0]  ovG_drop_cnt;

    logic        s_valid;
    logic [15:0] s_data;
    logic [3:0]  s_level;
    logic        s_full;
    logic        s_empty;
    logic [1:0]  s_drop_cnt;

    int n_chk;
    int n_fail;

    capture_fifo #(
        .PAR_DATA_BITS(16), .PAR_DEPTH_LOG2(3), .PAR_DROP_CNT_BITS(8)
    ) u_dut (
        .ib_clk(ib_clk), .ib_rst(ib_rst), .ib_capture_en(ib_capture_en),
        .ivG_data(ivG_data), .ib_clr_drop(ib_clr_drop),
        .ob_valid(ob_valid), .ib_ready(ib_ready), .ovG_data(ovG_data),
        .ovG_level(ovG_level), .ob_full(ob_full), .ob_empty(ob_empty),
        .ovG_drop_cnt(ovG_drop_cnt)
    );

    capture_fifo #(
        .PAR_DATA_BITS(16), .PAR_DEPTH_LOG2(3), .PAR_DROP_CNT_BITS(2)
    ) u_sat (
        .ib_clk(ib_clk), .ib_rst(ib_rst), .ib_capture_en(ib_capture_en),
        .ivG_data(ivG_data), .ib_clr_drop(ib_clr_drop),
        .ob_valid(s_valid), .ib_ready(ib_ready), .ovG_data(s_data),
        .ovG_level(s_level), .ob_full(s_full), .ob_empty(s_empty),
        .ovG_drop_cnt(s_drop_cnt)
    );

    initial ib_clk = 1'b0;
    always #5 ib_clk = ~ib_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ib_clk);
        #1;
    endtask

    task automatic fill(input int n, input int base);
        ib_ready      = 1'b0;
        ib_capture_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            ivG_data = 16'(base + i);
            tick();
        end
        ib_capture_en = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        ib_rst        = 1'b0;
        ib_capture_en = 1'b0;
        ivG_data      = '0;
        ib_clr_drop   = 1'b0;
        ib_ready      = 1'b0;
        tick();
        chk("rst_valid", 32'(ob_valid), 0);
        chk("rst_empty", 32'(ob_empty), 1);
        chk("rst_full", 32'(ob_full), 0);
        chk("rst_data", 32'(ovG_data), 0);
        chk("rst_level", 32'(ovG_level), 0);
        chk("rst_drop", 32'(ovG_drop_cnt), 0);
        tick();
        ib_rst = 1'b1;
        tick();

        fill(5, 1);
        chk("ord_level", 32'(ovG_level), 5);
        chk("ord_head", 32'(ovG_data), 1);
        chk("ord_valid", 32'(ob_valid), 1);
        ib_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("ord_data", 32'(ovG_data), 32'(i));
            tick();
        end
        chk("ord_empty", 32'(ob_empty), 1);
        chk("ord_novalid", 32'(ob_valid), 0);
        chk("ord_hold", 32'(ovG_data), 5);

        fill(8, 1);
        chk("ovf_full8", 32'(ob_full), 1);
        chk("ovf_level8", 32'(ovG_level), 8);
        fill(2, 9);
        chk("ovf_level", 32'(ovG_level), 8);
        chk("ovf_drop", 32'(ovG_drop_cnt), 2);
        ib_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_data", 32'(ovG_data), 32'(i));
            tick();
        end
        chk("ovf_empty", 32'(ob_empty), 1);

        fill(8, 1);
        chk("fp_full", 32'(ob_full), 1);
        ib_ready      = 1'b1;
        ib_capture_en = 1'b1;
        ivG_data      = 16'h00AA;
        chk("fp_head", 32'(ovG_data), 1);
        tick();
        ib_capture_en = 1'b0;
        chk("fp_level", 32'(ovG_level), 8);
        chk("fp_nodrop", 32'(ovG_drop_cnt), 2);
        for (int i = 2; i <= 8; i++) begin
            chk("fp_data", 32'(ovG_data), 32'(i));
            tick();
        end
        chk("fp_aa", 32'(ovG_data), 32'h00AA);
        tick();
        chk("fp_empty", 32'(ob_empty), 1);

        ib_ready      = 1'b1;
        ib_capture_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ivG_data = 16'(i);
            tick();
            chk("wrap_level", 32'(ovG_level), 1);
            chk("wrap_data", 32'(ovG_data), 32'(i));
        end
        ib_capture_en = 1'b0;
        tick();
        chk("wrap_empty", 32'(ob_empty), 1);
        chk("wrap_hold", 32'(ovG_data), 19);
        chk("wrap_nodrop", 32'(ovG_drop_cnt), 2);

        ib_clr_drop = 1'b1;
        tick();
        ib_clr_drop = 1'b0;
        chk("clr_drop", 32'(ovG_drop_cnt), 0);
        chk("clr_sdrop", 32'(s_drop_cnt), 0);
        fill(13, 1);
        chk("sat_drop8", 32'(ovG_drop_cnt), 5);
        chk("sat_drop2", 32'(s_drop_cnt), 3);
        ib_clr_drop   = 1'b1;
        ib_capture_en = 1'b1;
        tick();
        ib_clr_drop   = 1'b0;
        ib_capture_en = 1'b0;
        chk("clrd_drop8", 32'(ovG_drop_cnt), 1);
        chk("clrd_drop2", 32'(s_drop_cnt), 1);

        @(posedge ib_clk);
        #3;
        ib_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ob_valid), 0);
        chk("arst_level", 32'(ovG_level), 0);
        chk("arst_drop", 32'(ovG_drop_cnt), 0);
        chk("arst_data", 32'(ovG_data), 0);
        tick();
        ib_rst = 1'b1;
        ib_capture_en = 1'b1;
        ivG_data      = 16'h1234;
        tick();
        ib_capture_en = 1'b0;
        chk("post_valid", 32'(ob_valid), 1);
        chk("post_data", 32'(ovG_data), 32'h1234);
        chk("post_level", 32'(ovG_level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
